// File: rtl/dmu_lsu_if.sv
// dmu_lsu_if: request/response bundle between a load/store requester and dmu_lsu.
interface dmu_lsu_if #(parameter int WIDTH = 32);
    logic             req_valid;
    logic             req_ready;
    logic             write_en;
    logic             read_en;
    logic [2:0]       Funct3;
    logic [WIDTH-1:0] Mem_addr;
    logic [WIDTH-1:0] RS2_data;
    logic             resp_valid;
    logic [WIDTH-1:0] dmu_out_data;
    logic             misalign;

    modport master (
        output req_valid, write_en, read_en, Funct3, Mem_addr, RS2_data,
        input  req_ready, resp_valid, dmu_out_data, misalign
    );

    modport slave (
        input  req_valid, write_en, read_en, Funct3, Mem_addr, RS2_data,
        output req_ready, resp_valid, dmu_out_data, misalign
    );
endinterface

// File: rtl/dmu_lsu.sv
// dmu_lsu: 3-cycle load/store unit over a WIDTH x DEPTH byte-lane memory (IDLE -> ACCESS -> RESP).
// Optional macro DMU_MISALIGN_TRAP_EN traps misaligned accesses instead of aligning them down.
module dmu_lsu #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256
) (
    input logic      clk,
    input logic      rst,
    dmu_lsu_if.slave bus
);
    localparam int NB  = WIDTH / 8;
    localparam int OFF = $clog2(NB);
    localparam int AW  = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t             state_q, state_d;
    logic               we_q, we_d;
    logic [2:0]         f3_q, f3_d;
    logic [OFF+AW-1:0]  addr_q, addr_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               mis_q, mis_d;

    logic [WIDTH-1:0]   mem [DEPTH];

    logic               accept, legal, mis, mem_we;
    logic [OFF-1:0]     szm, off;
    logic [NB-1:0]      bmask;
    logic [WIDTH-1:0]   word, wsh, rsh, ld, wr_word;
    logic               unused_addr;

    assign unused_addr      = ^(bus.Mem_addr >> (OFF + AW));
    assign bus.req_ready    = rst && state_q == IDLE;
    assign bus.resp_valid   = state_q == RESP;
    assign bus.dmu_out_data = dout_q;
    assign bus.misalign     = mis_q;
    assign accept = bus.req_valid && bus.req_ready && (bus.write_en ^ bus.read_en);

    always_comb begin
        szm = OFF'((1 << f3_q[1:0]) - 1);
`ifdef DMU_MISALIGN_TRAP_EN
        mis = |(addr_q[OFF-1:0] & szm);
        off = addr_q[OFF-1:0];
`else
        mis = 1'b0;
        off = addr_q[OFF-1:0] & ~szm;
`endif
        legal = we_q ? (!f3_q[2] && (f3_q[1:0] != 2'b11 || WIDTH == 64))
                     : (f3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101} ||
                        (WIDTH == 64 && (f3_q == 3'b011 || f3_q == 3'b110)));
        word  = mem[addr_q[OFF+AW-1:OFF]];
        rsh   = word >> {off, 3'b000};
        wsh   = data_q << {off, 3'b000};
        bmask = NB'((1 << (1 << f3_q[1:0])) - 1) << off;
        wr_word = word;
        for (int i = 0; i < NB; i++)
            if (bmask[i]) wr_word[i*8 +: 8] = wsh[i*8 +: 8];
        ld = f3_q == 3'b000 ? WIDTH'($signed(rsh[7:0]))  :
             f3_q == 3'b001 ? WIDTH'($signed(rsh[15:0])) :
             f3_q == 3'b010 ? WIDTH'($signed(rsh[31:0])) :
             f3_q == 3'b100 ? WIDTH'(rsh[7:0])           :
             f3_q == 3'b101 ? WIDTH'(rsh[15:0])          :
             f3_q == 3'b110 ? WIDTH'(rsh[31:0])          : rsh;
    end

    always_comb begin
        state_d = state_q == IDLE   ? (accept ? ACCESS : IDLE) :
                  state_q == ACCESS ? RESP : IDLE;
        we_d    = accept ? bus.write_en : we_q;
        f3_d    = accept ? bus.Funct3 : f3_q;
        addr_d  = accept ? bus.Mem_addr[OFF+AW-1:0] : addr_q;
        data_d  = accept ? bus.RS2_data : data_q;
        // Results are captured on the commit edge and then held until the next one.
        dout_d  = state_q == ACCESS ? ((we_q || !legal || mis) ? '0 : ld) : dout_q;
        mis_d   = state_q == ACCESS ? (legal && mis) : mis_q;
        mem_we  = state_q == ACCESS && we_q && legal && !mis;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            dout_q  <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            dout_q  <= dout_d;
            mis_q   <= mis_d;
        end
    end

    // Storage is deliberately not reset; a reset during ACCESS leaves state_q at IDLE so nothing commits.
    always_ff @(posedge clk) begin
        if (mem_we) mem[addr_q[OFF+AW-1:OFF]] <= wr_word;
    end
endmodule

// File: tb/tb_dmu_lsu.sv
// tb_dmu_lsu: randomized scoreboard bench for dmu_lsu (WIDTH=32, DEPTH=256) with a byte-array memory model.
module tb_dmu_lsu;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmu_lsu_if #(.WIDTH(32)) bus();
    dmu_lsu #(.WIDTH(32), .DEPTH(256)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] d;
        logic        m;
        bit          chk_m;
        int          due;
    } exp_t;

    exp_t        q[$];
    exp_t        e_mon;
    logic [7:0]  mb [1024];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_d;
    logic        last_m;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string nm, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic void model(bit we, logic [2:0] f3, logic [31:0] a, logic [31:0] d, int due);
        exp_t        e;
        int          n  = 1 << f3[1:0];
        int          ad = int'(a[9:0]);
        bit          legal = we ? (f3 < 3'd3) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        logic [31:0] v  = '0;
        e.due = due;
        e.d = '0;
        e.m = 1'b0;
        e.chk_m = legal;
        if (legal) begin
`ifdef DMU_MISALIGN_TRAP_EN
            e.m = (ad % n) != 0;
`endif
            ad = ad - ad % n;
            if (!e.m) begin
                if (we) begin
                    for (int k = 0; k < n; k++) mb[ad + k] = d[8*k +: 8];
                end else begin
                    for (int k = 0; k < n; k++) v = v | (32'(mb[ad + k]) << (8 * k));
                    if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
                    e.d = v;
                end
            end
        end
        q.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            last_d = '0;
            last_m = 1'b0;
        end else if (bus.resp_valid) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected 0 (cycle %0d)", cyc);
            end else begin
                e_mon = q.pop_front();
                check("data", bus.dmu_out_data, e_mon.d);
                if (e_mon.chk_m) check("misalign", 32'(bus.misalign), 32'(e_mon.m));
                check("latency", cyc, e_mon.due);
            end
            last_d = bus.dmu_out_data;
            last_m = bus.misalign;
        end else begin
            check("hold_data", bus.dmu_out_data, last_d);
            check("hold_mis", 32'(bus.misalign), 32'(last_m));
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus.req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: got req_ready=0 expected 1 (cycle %0d)", cyc);
        end
    endtask

    task automatic issue(bit we, bit re, logic [2:0] f3, logic [31:0] a, logic [31:0] d);
        wait_ready();
        bus.req_valid = 1'b1;
        bus.write_en  = we;
        bus.read_en   = re;
        bus.Funct3    = f3;
        bus.Mem_addr  = a;
        bus.RS2_data  = d;
        if (we ^ re) model(we, f3, a, d, cyc + 2);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.write_en  = 1'($urandom);
        bus.read_en   = 1'($urandom);
        bus.Funct3    = 3'($urandom);
        bus.Mem_addr  = $urandom;
        bus.RS2_data  = $urandom;
        if (!(we ^ re)) check("ignored_ready", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        int n;
        bus.req_valid = 1'b0;
        bus.write_en  = 1'b0;
        bus.read_en   = 1'b0;
        bus.Funct3    = 3'd0;
        bus.Mem_addr  = '0;
        bus.RS2_data  = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_data", bus.dmu_out_data, 32'd0);
        check("rst_mis", 32'(bus.misalign), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(bus.req_ready), 32'd1);

        for (int i = 0; i < 256; i++) issue(1, 0, 3'b010, 32'(i * 4), $urandom);

        issue(1, 0, 3'b010, 32'h10, 32'hDEADBEEF);
        issue(0, 1, 3'b010, 32'h10, 32'h0);
        issue(1, 0, 3'b000, 32'h11, 32'h80);
        issue(0, 1, 3'b000, 32'h11, 32'h0);
        issue(0, 1, 3'b100, 32'h11, 32'h0);
        issue(0, 1, 3'b010, 32'h10, 32'h0);
        issue(1, 0, 3'b010, 32'h400, 32'h12345678);
        issue(0, 1, 3'b010, 32'h0, 32'h0);
        issue(0, 1, 3'b001, 32'h13, 32'h0);
        issue(1, 1, 3'b010, 32'h10, 32'h55555555);
        issue(0, 0, 3'b010, 32'h10, 32'h55555555);
        issue(1, 0, 3'b011, 32'h10, 32'hFFFFFFFF);
        issue(0, 1, 3'b110, 32'h10, 32'h0);
        issue(0, 1, 3'b010, 32'h10, 32'h0);

        wait_ready();
        bus.req_valid = 1'b1;
        bus.write_en  = 1'b1;
        bus.read_en   = 1'b0;
        bus.Funct3    = 3'b010;
        bus.Mem_addr  = 32'h20;
        bus.RS2_data  = 32'hCAFEF00D;
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("abort_ready", 32'(bus.req_ready), 32'd0);
        check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("abort_data", bus.dmu_out_data, 32'd0);
        check("abort_mis", 32'(bus.misalign), 32'd0);
        @(negedge clk);
        check("abort_resp_hidden", 32'(bus.resp_valid), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_abort", 32'(bus.req_ready), 32'd1);
        issue(0, 1, 3'b010, 32'h20, 32'h0);

        for (int i = 0; i < 400; i++) begin
            bit we, re;
            logic [31:0] a;
            we = 1'($urandom);
            re = !we;
            if ($urandom_range(0, 9) == 0) re = we;
            a = $urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, 63));
            issue(we, re, 3'($urandom_range(0, 7)), a, $urandom);
        end

        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending responses expected 0", q.size());
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
